// File: rtl/vram_pkg.sv
// Shared VRAM definitions: scan FSM state encoding and bus widths.
package vram_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_t;

endpackage : vram_pkg

// File: rtl/vram_scan_arbiter.sv
// VRAM port arbiter: during hblank the display line fetch owns the port for
// WORDS_PER_LINE cycles and fills one line-buffer bank; at all other times the
// CPU gets a combinational single-cycle grant.
module vram_scan_arbiter
   import vram_pkg::*;
#(
   parameter int          WORDS_PER_LINE = 80,
   parameter int          FETCH_START    = 640,
   parameter int          LINE           = 799,
   parameter int          VA_END         = 479,
   parameter int          SCREEN         = 524,
   parameter logic [15:0] BASE_ADDR      = 16'h0000
) (
   input  logic              clk_pix,
   input  logic              rst,
   input  logic [9:0]        sx,
   input  logic [9:0]        sy,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic              lb_bank,
   output logic [6:0]        lb_addr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              fetch_late
);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [15:0]       r_word;
   logic [15:0]       w_word_nxt;
   logic [9:0]        r_line;
   logic [9:0]        w_line_nxt;
   logic              r_lb_bank;
   logic              w_lb_bank_nxt;
   logic              r_lb_we;
   logic [6:0]        r_lb_addr;
   logic              r_cpu_rvalid;
   logic              r_fetch_late;
   logic [9:0]        w_next_line;
   logic              w_trigger;
   logic [ADDR_W-1:0] w_fetch_addr;
   logic              w_cpu_gnt;

   // The line about to be displayed wraps to 0 after the last frame line.
   assign w_next_line  = (sy == 10'(SCREEN)) ? 10'd0 : sy + 10'd1;
   assign w_trigger    = (sx == 10'(FETCH_START)) && (w_next_line <= 10'(VA_END));
   // 16-bit arithmetic intentionally wraps around the VRAM address space.
   assign w_fetch_addr = BASE_ADDR + (16'(r_line) * 16'(WORDS_PER_LINE)) + r_word;

   // Next-state logic: trigger only from IDLE, one read per FETCH cycle, one DRAIN cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_word_nxt    = r_word;
      w_line_nxt    = r_line;
      w_lb_bank_nxt = r_lb_bank;
      case (r_state)
         ST_IDLE: begin
            if (w_trigger) begin
               w_state_nxt = ST_FETCH;
               w_word_nxt  = 16'd0;
               w_line_nxt  = w_next_line;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (r_word == 16'(WORDS_PER_LINE - 1)) begin
               w_state_nxt = ST_DRAIN;
               w_word_nxt  = 16'd0;
            end else begin
               w_word_nxt  = r_word + 16'd1;
            end
         end
         ST_DRAIN: begin
            w_state_nxt   = ST_IDLE;
            w_lb_bank_nxt = ~r_lb_bank;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_word_nxt  = 16'd0;
         end
      endcase
   end

   // VRAM port mux: fetch has strict priority, CPU is granted in the same cycle otherwise.
   always_comb begin
      w_cpu_gnt = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      if (rst) begin
         w_cpu_gnt = 1'b0;
      end else if (r_state == ST_FETCH) begin
         mem_en   = 1'b1;
         mem_addr = w_fetch_addr;
      end else if (cpu_req && !((r_state == ST_IDLE) && w_trigger)) begin
         w_cpu_gnt = 1'b1;
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else begin
         w_cpu_gnt = 1'b0;
      end
   end

   // State, counters and the one-cycle-delayed strobes that track VRAM read latency.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_word       <= 16'd0;
         r_line       <= 10'd0;
         r_lb_bank    <= 1'b0;
         r_lb_we      <= 1'b0;
         r_lb_addr    <= 7'd0;
         r_cpu_rvalid <= 1'b0;
         r_fetch_late <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_word       <= w_word_nxt;
         r_line       <= w_line_nxt;
         r_lb_bank    <= w_lb_bank_nxt;
         r_lb_we      <= (r_state == ST_FETCH);
         r_lb_addr    <= r_word[6:0];
         r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
         r_fetch_late <= r_fetch_late | ((r_state != ST_IDLE) && (sx == 10'(LINE)));
      end
   end

   assign cpu_gnt    = w_cpu_gnt;
   assign cpu_rvalid = r_cpu_rvalid;
   assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : 16'h0000;
   assign lb_we      = r_lb_we;
   assign lb_addr    = r_lb_addr;
   assign lb_wdata   = r_lb_we ? mem_rdata : 16'h0000;
   assign lb_bank    = r_lb_bank;
   assign fetch_late = r_fetch_late;

endmodule : vram_scan_arbiter

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: line fetch, CPU arbitration,
// reset behaviour and the late-fetch flag (second instance, 200 words/line).
module tb_vram_scan_arbiter;

   logic        clk_pix = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sx = 10'd0;
   logic [9:0]  sy = 10'd0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [15:0] cpu_wdata = 16'h0000;
   logic [15:0] mem_rdata = 16'h0000;

   logic        cpu_gnt, cpu_rvalid, mem_en, mem_we, lb_we, lb_bank, fetch_late;
   logic [15:0] cpu_rdata, mem_addr, mem_wdata, lb_wdata;
   logic [6:0]  lb_addr;

   logic        u2_cpu_gnt, u2_cpu_rvalid, u2_mem_en, u2_mem_we, u2_lb_we, u2_lb_bank, u2_fetch_late;
   logic [15:0] u2_cpu_rdata, u2_mem_addr, u2_mem_wdata, u2_lb_wdata;
   logic [6:0]  u2_lb_addr;

   int vectors = 0;
   int miscompares = 0;
   logic exp_bank = 1'b0;

   // scoreboards: {expected cycle index, address} and {cycle index, lb addr, data}
   logic [23:0] q_rd[$];
   logic [30:0] q_lb[$];
   logic [15:0] q_cpu[$];

   vram_scan_arbiter dut (
      .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr),
      .lb_wdata(lb_wdata), .fetch_late(fetch_late)
   );

   vram_scan_arbiter #(.WORDS_PER_LINE(200)) dut_long (
      .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(u2_cpu_gnt), .cpu_rdata(u2_cpu_rdata), .cpu_rvalid(u2_cpu_rvalid),
      .mem_en(u2_mem_en), .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
      .mem_rdata(mem_rdata), .lb_we(u2_lb_we), .lb_bank(u2_lb_bank), .lb_addr(u2_lb_addr),
      .lb_wdata(u2_lb_wdata), .fetch_late(u2_fetch_late)
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // VRAM model: one-cycle read latency, contents are a function of the address
   always @(posedge clk_pix) mem_rdata <= mem_fn(mem_addr);

   // go to just after the next rising edge; inputs are driven here, sampled #4 later
   task automatic adv();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
      adv(); adv(); #4;
      vectors++;
      if (cpu_gnt !== 1'b0 || mem_en !== 1'b0 || lb_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: gnt=%b en=%b lb_we=%b rvalid=%b, required all 0", cpu_gnt, mem_en, lb_we, cpu_rvalid);
      end
      vectors++;
      if (lb_bank !== 1'b0 || fetch_late !== 1'b0 || lb_wdata !== 16'h0 || cpu_rdata !== 16'h0 || lb_addr !== 7'h0) begin
         miscompares++;
         $display("FAIL reset_state: bank=%b late=%b lb_wdata=%h rdata=%h lb_addr=%h, required 0", lb_bank, fetch_late, lb_wdata, cpu_rdata, lb_addr);
      end
      adv(); rst = 1'b0; cpu_req = 1'b0;
   endtask

   task automatic test_fetch(input logic [9:0] line_sy, input bit expect_fetch, input logic [15:0] first_addr);
      logic [23:0] rd;
      logic [30:0] lb;
      sy = line_sy; sx = 10'd639; cpu_req = 1'b0;
      adv(); sx = 10'd640; #4;
      vectors++;
      if (mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL trigger_cycle_idle sy=%0d: mem_en=%b, required 0", line_sy, mem_en);
      end
      if (expect_fetch) begin
         for (int w = 0; w < 80; w++) begin
            q_rd.push_back({8'(w + 1), first_addr + 16'(w)});
            q_lb.push_back({8'(w + 2), 7'(w), mem_fn(first_addr + 16'(w))});
         end
      end
      for (int k = 1; k <= 90; k++) begin
         adv(); sx = sx + 10'd1; #4;
         if (mem_en === 1'b1) begin
            vectors++;
            if (q_rd.size() == 0) begin
               miscompares++;
               $display("FAIL fetch_rd_extra sy=%0d cycle %0d: addr=%h, required no read", line_sy, k, mem_addr);
            end else begin
               rd = q_rd.pop_front();
               if ({8'(k), mem_addr} !== rd || mem_we !== 1'b0) begin
                  miscompares++;
                  $display("FAIL fetch_rd sy=%0d: cycle %0d addr %h we %b, required cycle %0d addr %h we 0", line_sy, k, mem_addr, mem_we, rd[23:16], rd[15:0]);
               end
            end
         end
         if (lb_we === 1'b1) begin
            vectors++;
            if (q_lb.size() == 0) begin
               miscompares++;
               $display("FAIL fetch_lb_extra sy=%0d cycle %0d: lb_addr=%0d, required no write", line_sy, k, lb_addr);
            end else begin
               lb = q_lb.pop_front();
               if ({8'(k), lb_addr, lb_wdata} !== lb) begin
                  miscompares++;
                  $display("FAIL fetch_lb sy=%0d: cycle %0d idx %0d data %h, required cycle %0d idx %0d data %h", line_sy, k, lb_addr, lb_wdata, lb[30:23], lb[22:16], lb[15:0]);
               end
            end
         end
      end
      vectors++;
      if (q_rd.size() != 0 || q_lb.size() != 0) begin
         miscompares++;
         $display("FAIL fetch_missing sy=%0d: %0d reads and %0d lb writes outstanding, required 0", line_sy, q_rd.size(), q_lb.size());
         q_rd.delete(); q_lb.delete();
      end
      if (expect_fetch) exp_bank = ~exp_bank;
      vectors++;
      if (lb_bank !== exp_bank) begin
         miscompares++;
         $display("FAIL fetch_bank sy=%0d: lb_bank=%b, required %b", line_sy, lb_bank, exp_bank);
      end
   endtask

   task automatic test_cpu_arb();
      logic [15:0] exp_d;
      sy = 10'd10; sx = 10'd639; cpu_req = 1'b0;
      adv(); sx = 10'd640; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; #4;
      vectors++;
      if (cpu_gnt !== 1'b0) begin
         miscompares++;
         $display("FAIL arb_trigger: cpu_gnt=%b, required 0", cpu_gnt);
      end
      for (int k = 1; k <= 80; k++) begin
         adv(); sx = sx + 10'd1; #4;
         vectors++;
         if (cpu_gnt !== 1'b0 || mem_addr !== 16'(880 + k - 1)) begin
            miscompares++;
            $display("FAIL arb_fetch cycle %0d: gnt=%b addr=%h, required gnt 0 addr %h", k, cpu_gnt, mem_addr, 16'(880 + k - 1));
         end
      end
      adv(); sx = sx + 10'd1; #4;
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h1234) begin
         miscompares++;
         $display("FAIL arb_drain_grant: gnt=%b en=%b we=%b addr=%h, required 1 1 0 1234", cpu_gnt, mem_en, mem_we, mem_addr);
      end
      q_cpu.push_back(mem_fn(16'h1234));
      adv(); sx = sx + 10'd1; cpu_req = 1'b0; #4;
      exp_bank = ~exp_bank;
      vectors++;
      if (cpu_rvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL arb_rvalid: cpu_rvalid=%b, required 1", cpu_rvalid);
         q_cpu.delete();
      end else begin
         exp_d = q_cpu.pop_front();
         if (cpu_rdata !== exp_d) begin
            miscompares++;
            $display("FAIL arb_rdata: cpu_rdata=%h, required %h", cpu_rdata, exp_d);
         end
      end
      vectors++;
      if (lb_bank !== exp_bank) begin
         miscompares++;
         $display("FAIL arb_bank: lb_bank=%b, required %b", lb_bank, exp_bank);
      end
   endtask

   task automatic test_cpu_write();
      sx = 10'd100; sy = 10'd20;
      adv(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBEEF; cpu_wdata = 16'hC0DE; #4;
      vectors++;
      if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'hBEEF || mem_wdata !== 16'hC0DE) begin
         miscompares++;
         $display("FAIL cpu_write: gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 beef c0de", cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      adv(); cpu_req = 1'b0; cpu_we = 1'b0; #4;
      vectors++;
      if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL cpu_write_after: rvalid=%b mem_en=%b, required 0 0", cpu_rvalid, mem_en);
      end
   endtask

   task automatic test_reset_mid();
      #4;
      vectors++;
      if (lb_bank !== exp_bank) begin
         miscompares++;
         $display("FAIL pre_reset_bank: lb_bank=%b, required %b", lb_bank, exp_bank);
      end
      sy = 10'd10; sx = 10'd639; cpu_req = 1'b0;
      adv(); sx = 10'd640;
      for (int k = 1; k <= 40; k++) begin
         adv(); sx = sx + 10'd1;
      end
      adv(); sx = sx + 10'd1; rst = 1'b1;
      adv(); sx = sx + 10'd1; rst = 1'b0; #4;
      exp_bank = 1'b0;
      for (int k = 0; k < 60; k++) begin
         vectors++;
         if (lb_we !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort cycle %0d: lb_we=%b mem_en=%b, required 0 0", k, lb_we, mem_en);
         end
         adv(); sx = sx + 10'd1; #4;
      end
      vectors++;
      if (lb_bank !== exp_bank) begin
         miscompares++;
         $display("FAIL reset_abort_bank: lb_bank=%b, required 0", lb_bank);
      end
   endtask

   task automatic test_late();
      sy = 10'd10; sx = 10'd639;
      adv(); sx = 10'd640;
      while (sx != 10'd799) begin
         adv(); sx = sx + 10'd1;
      end
      #4;
      vectors++;
      if (u2_fetch_late !== 1'b0) begin
         miscompares++;
         $display("FAIL late_early: fetch_late=%b at sx 799, required 0", u2_fetch_late);
      end
      adv(); sx = 10'd0; sy = 10'd11; #4;
      vectors++;
      if (u2_fetch_late !== 1'b1 || fetch_late !== 1'b0) begin
         miscompares++;
         $display("FAIL late_set: long=%b short=%b, required 1 0", u2_fetch_late, fetch_late);
      end
      for (int k = 0; k < 300; k++) begin
         adv(); sx = sx + 10'd1;
      end
      #4;
      vectors++;
      if (u2_fetch_late !== 1'b1) begin
         miscompares++;
         $display("FAIL late_sticky: fetch_late=%b, required 1", u2_fetch_late);
      end
      adv(); rst = 1'b1;
      adv(); rst = 1'b0; #4;
      vectors++;
      if (u2_fetch_late !== 1'b0) begin
         miscompares++;
         $display("FAIL late_clear: fetch_late=%b after rst, required 0", u2_fetch_late);
      end
   endtask

   initial begin
      test_reset();
      test_fetch(10'd10, 1'b1, 16'd880);
      test_fetch(10'd524, 1'b1, 16'd0);
      test_fetch(10'd479, 1'b0, 16'd0);
      test_cpu_arb();
      test_cpu_write();
      test_reset_mid();
      test_late();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_vram_scan_arbiter
